// File: rtl/seq_divider4.sv
// Sequential unsigned restoring divider: one trial subtraction per cycle,
// start/done handshake, divide-by-zero flagged without running iterations.
module seq_divider4 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             busy,
   output logic             done,
   output logic             dz
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             dz_q, dz_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;

   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;
   logic             carry;
   logic             no_borrow;

   always_comb begin
      trial        = {r_q, q_q[WIDTH-1]};
      {carry, diff} = {1'b0, trial} + {1'b0, ~{1'b0, d_q}} + {{(WIDTH+1){1'b0}}, 1'b1};
      // With no borrow the difference is below D, so its top bit is always clear.
      no_borrow    = carry & ~diff[WIDTH];

      state_d = state_q;
      q_d     = q_q;
      r_d     = r_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      dz_d    = dz_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (B == '0) begin
                  q_d     = '1;
                  r_d     = A;
                  dz_d    = 1'b1;
                  state_d = DONE;
               end else begin
                  q_d     = A;
                  r_d     = '0;
                  d_d     = B;
                  cnt_d   = CW'(WIDTH);
                  dz_d    = 1'b0;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            r_d   = no_borrow ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
            q_d   = {q_q[WIDTH-2:0], no_borrow};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      done_d = (state_d == DONE);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         q_q     <= '0;
         r_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         dz_q    <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         r_q     <= r_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         dz_q    <= dz_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign Q    = q_q;
   assign R    = r_q;
   assign dz   = dz_q;
   assign done = done_q;
   assign busy = busy_q;

endmodule
